// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences the Rx32 IF stage: drives the PC register's en/d/clear inputs,
//   runs req/ack fetch transactions to instruction memory, holds the fetched
//   instruction while decode stalls, and squashes a stale in-flight fetch
//   after a branch or trap redirect.
//
//   Optional build macro FETCH_PERF_EN adds two saturating 32-bit event
//   counters: perf_stall_o (cycles spent holding a stalled instruction) and
//   perf_flush_o (cycles in which a redirect was accepted).

module fetch_sequencer #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
    parameter int unsigned       INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             br_taken_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             trap_i,
    input  logic [WIDTH-1:0] trap_vec_i,
    input  logic [WIDTH-1:0] pc_q_i,
    output logic             pc_en_o,
    output logic [WIDTH-1:0] pc_d_o,
    output logic             pc_clear_o,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    output logic             if_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_o,
    output logic [31:0]      perf_flush_o
`endif
);

    // BOOT  : one cycle of PC clear after reset, no fetch issued
    // REQ   : fetch at the current PC outstanding
    // HOLD  : instruction delivered, decode stalled, IF/ID holds it
    // DRAIN : fetch to a squashed address still outstanding, result discarded
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] addr_q;      // address of the fetch that a redirect may orphan
    logic             redirect;
    logic [WIDTH-1:0] target_raw;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;

    assign redirect   = trap_i | br_taken_i;
    // Trap has priority over branch; the target is forced word aligned.
    assign target_raw = trap_i ? trap_vec_i : br_target_i;
    assign target     = target_raw & ALIGN_MASK;
    // Sequential PC wraps silently modulo 2^WIDTH.
    assign pc_inc     = pc_q_i + PC_STEP;

    // Next-state and output decode; all outputs forced quiet (except clear) in reset.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        state_nxt   = state;
        pc_en_o     = 1'b0;
        pc_d_o      = '0;
        pc_clear_o  = 1'b0;
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        if_valid_o  = 1'b0;

        if (!reset_n) begin
            pc_clear_o = 1'b1;
            state_nxt  = S_BOOT;
        end else begin
            case (state)
                S_BOOT: begin
                    pc_clear_o = 1'b1;
                    state_nxt  = S_REQ;
                end

                S_REQ: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc_q_i;
                    if (imem_ack_i && redirect) begin
                        // Instruction arrived but is on the wrong path: drop it.
                        pc_en_o = 1'b1;
                        pc_d_o  = target;
                    end else if (imem_ack_i && stall_i) begin
                        if_valid_o = 1'b1;
                        state_nxt  = S_HOLD;
                    end else if (imem_ack_i) begin
                        if_valid_o = 1'b1;
                        pc_en_o    = 1'b1;
                        pc_d_o     = pc_inc;
                    end else if (redirect) begin
                        // Fetch still in flight: it must complete before re-issuing.
                        pc_en_o   = 1'b1;
                        pc_d_o    = target;
                        state_nxt = S_DRAIN;
                    end
                end

                S_HOLD: begin
                    if_valid_o = 1'b1;
                    if (redirect) begin
                        if_valid_o = 1'b0;
                        pc_en_o    = 1'b1;
                        pc_d_o     = target;
                        state_nxt  = S_REQ;
                    end else if (!stall_i) begin
                        pc_en_o   = 1'b1;
                        pc_d_o    = pc_inc;
                        state_nxt = S_REQ;
                    end
                end

                S_DRAIN: begin
                    // Keep the orphaned request stable until imem acknowledges it.
                    imem_req_o  = 1'b1;
                    imem_addr_o = addr_q;
                    if (redirect) begin
                        pc_en_o = 1'b1;
                        pc_d_o  = target;
                    end
                    if (imem_ack_i) begin
                        state_nxt = S_REQ;
                    end
                end

                default: begin
                    state_nxt = S_BOOT;
                end
            endcase
        end
    end

    // State register and capture of the address currently being requested.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state  <= S_BOOT;
            addr_q <= RESET_VAL;
        end else begin
            state <= state_nxt;
            if (state == S_REQ) begin
                addr_q <= pc_q_i;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        flush_evt;

    // A redirect is accepted in every state except BOOT.
    assign flush_evt = redirect && (state != S_BOOT);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == S_HOLD) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_o = reset_n ? stall_cnt : 32'd0;
    assign perf_flush_o = reset_n ? flush_cnt : 32'd0;
`endif

endmodule
